reg_wr_arbiter: RTL and testbench

Write-port controller for the 32x32 register bank. After reset it sequences a clearing sweep that zeroes registers 1..31. It then shares the bank's single write port between two writeback requesters, A (ALU result) and B (load/memory result), using round-robin arbitration and a valid/ready handshake. It sits directly in front of the register bank and drives the bank's regwrite, regdst, wa and wd inputs from a one-stage output register.

---
 rtl/reg_wr_arbiter_if.sv | 27 ++
 rtl/reg_wr_arbiter.sv | 78 +++++++
 tb/tb_reg_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wr_arbiter_if.sv
// Handshake and bank-side signals of the register-bank write-port controller.
// slave: the controller; master: the requesters and bank driven from outside.
interface reg_wr_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        regwrite;
    logic        regdst;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        init_done;

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, regwrite, regdst, wa, wd, init_done
    );

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, regwrite, regdst, wa, wd, init_done
    );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Write-port controller for the 32x32 register bank: zeroes registers 1..31
// after reset, then round-robins the write port between requesters A and B.
module reg_wr_arbiter (
    input logic             clk,
    input logic             rst_n,
    reg_wr_arbiter_if.slave bus
);

    typedef enum logic {INIT, RUN} state_t;
    typedef enum logic {GRANT_A, GRANT_B} grant_t;

    state_t     state, state_next;
    grant_t     last_grant;
    logic [4:0] cnt;
    logic       grant_a, grant_b;
    logic       take_a, take_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == INIT && cnt == 5'd31) state_next = RUN;
    end

    // On contention the requester that did not win last time gets the port.
    always_comb begin
        grant_a     = bus.a_valid & (~bus.b_valid | (last_grant == GRANT_B));
        grant_b     = bus.b_valid & (~bus.a_valid | (last_grant == GRANT_A));
        bus.a_ready = (state == RUN) & grant_a;
        bus.b_ready = (state == RUN) & grant_b;
    end

    assign bus.regdst = 1'b1;
    assign take_a     = bus.a_valid & bus.a_ready;
    assign take_b     = bus.b_valid & bus.b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= 5'd1;
            last_grant    <= GRANT_B;
            bus.regwrite  <= 1'b0;
            bus.wa        <= '0;
            bus.wd        <= '0;
            bus.init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    bus.regwrite <= 1'b1;
                    bus.wa       <= cnt;
                    bus.wd       <= '0;
                    cnt          <= cnt + 5'd1;
                    if (cnt == 5'd31) bus.init_done <= 1'b1;
                end
                RUN: begin
                    // Address 0 completes the handshake but never reaches the bank.
                    if (take_a) begin
                        last_grant   <= GRANT_A;
                        bus.wa       <= bus.a_addr;
                        bus.wd       <= bus.a_data;
                        bus.regwrite <= |bus.a_addr;
                    end else if (take_b) begin
                        last_grant   <= GRANT_B;
                        bus.wa       <= bus.b_addr;
                        bus.wd       <= bus.b_data;
                        bus.regwrite <= |bus.b_addr;
                    end else begin
                        bus.regwrite <= 1'b0;
                    end
                end
                default: bus.regwrite <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter: directed scenarios followed by random
// traffic, checked against a rule-level arbitration model and a bank model.
module tb_reg_wr_arbiter;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int unsigned stamp;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic gaps = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc;

    req_t a_q[$];
    req_t b_q[$];
    wr_t  exp_q[$];

    logic [31:0] bank[32];
    logic [31:0] ref_rf[32];

    reg_wr_arbiter_if bus ();

    reg_wr_arbiter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Register bank: no reset, written at wa when regwrite is high.
    initial begin
        for (int i = 0; i < 32; i++) begin
            bank[i]   <= 32'hC000_0000 | 32'(i * 7 + 1);
            ref_rf[i]  = 32'hC000_0000 | 32'(i * 7 + 1);
        end
    end

    always @(posedge clk) begin
        if (bus.regwrite && bus.regdst) bank[bus.wa] <= bus.wd;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Requester drivers: hold valid/addr/data until accepted.
    initial begin
        logic acc;
        req_t it;
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        forever begin
            @(negedge clk);
            acc = bus.a_valid && bus.a_ready;
            @(posedge clk); #1;
            if (!bus.a_valid || acc) begin
                if (a_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                    it = a_q.pop_front();
                    bus.a_valid = 1'b1; bus.a_addr = it.addr; bus.a_data = it.data;
                end else begin
                    bus.a_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        logic acc;
        req_t it;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        forever begin
            @(negedge clk);
            acc = bus.b_valid && bus.b_ready;
            @(posedge clk); #1;
            if (!bus.b_valid || acc) begin
                if (b_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                    it = b_q.pop_front();
                    bus.b_valid = 1'b1; bus.b_addr = it.addr; bus.b_data = it.data;
                end else begin
                    bus.b_valid = 1'b0;
                end
            end
        end
    end

    // Reference model: sweep schedule, round-robin rule, expected bank writes.
    logic        m_last_a;
    logic        sweep_pushed;
    logic        pa_pend, pb_pend;
    logic [37:0] pa_save, pb_save;
    always @(negedge clk) begin
        logic run, ega, egb;
        chk("regdst", 64'(bus.regdst), 64'd1);
        if (!rst_n) begin
            exp_q.delete();
            m_last_a     = 1'b0;
            sweep_pushed = 1'b0;
            pa_pend      = 1'b0;
            pb_pend      = 1'b0;
            chk("reset_outputs", 64'({bus.regwrite, bus.init_done, bus.a_ready, bus.b_ready}), 64'd0);
        end else begin
            if (!sweep_pushed) begin
                for (int i = 1; i <= 31; i++)
                    exp_q.push_back('{addr: 5'(i), data: 32'd0, stamp: cyc + 32'(i)});
                sweep_pushed = 1'b1;
            end
            if (pa_pend) chk("a_stable", 64'({bus.a_valid, bus.a_addr, bus.a_data}), 64'(pa_save));
            if (pb_pend) chk("b_stable", 64'({bus.b_valid, bus.b_addr, bus.b_data}), 64'(pb_save));
            run = (cyc >= 31);
            chk("init_done", 64'(bus.init_done), 64'(run));
            ega = run && bus.a_valid && (!bus.b_valid || !m_last_a);
            egb = run && bus.b_valid && (!bus.a_valid || m_last_a);
            chk("readies", 64'({bus.a_ready, bus.b_ready}), 64'({ega, egb}));
            if (ega) begin
                m_last_a = 1'b1;
                if (bus.a_addr != 0) exp_q.push_back('{addr: bus.a_addr, data: bus.a_data, stamp: cyc + 1});
            end else if (egb) begin
                m_last_a = 1'b0;
                if (bus.b_addr != 0) exp_q.push_back('{addr: bus.b_addr, data: bus.b_data, stamp: cyc + 1});
            end
            pa_pend = bus.a_valid && !ega;
            pb_pend = bus.b_valid && !egb;
            pa_save = {bus.a_valid, bus.a_addr, bus.a_data};
            pb_save = {bus.b_valid, bus.b_addr, bus.b_data};
        end
    end

    // Monitor: every bank write must match the oldest expected write, on time.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (bus.regwrite) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'({bus.wa, bus.wd}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wa", 64'(bus.wa), 64'(e.addr));
                    chk("wd", 64'(bus.wd), 64'(e.data));
                    chk("write_cycle", 64'(cyc), 64'(e.stamp));
                    ref_rf[e.addr] = e.data;
                end
            end else if (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_write", 64'(bus.regwrite), 64'd1);
            end
        end
    end

    task automatic wait_init();
        logic ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.init_done;
        end
        chk("init_reached", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle(input int unsigned bound);
        logic ok = 1'b0;
        for (int unsigned i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            ok = (a_q.size() == 0) && (b_q.size() == 0) && !bus.a_valid && !bus.b_valid;
        end
        chk("idle_reached", 64'(ok), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // A request pending across reset and the whole sweep.
        a_q.push_back('{addr: 5'd9, data: 32'h0BAD_F00D});
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_init();
        wait_idle(20);
        for (int i = 1; i < 32; i++) begin
            if (i != 9) chk("swept_zero", 64'(bank[i]), 64'd0);
        end
        chk("rd9", 64'(bank[9]), 64'h0BAD_F00D);

        a_q.push_back('{addr: 5'd5, data: 32'hDEAD_BEEF});
        wait_idle(20);
        chk("rd5", 64'(bank[5]), 64'hDEAD_BEEF);

        b_q.push_back('{addr: 5'd0, data: 32'hFFFF_FFFF});
        wait_idle(20);
        chk("rd0", 64'(bank[0]), 64'hC000_0001);

        @(posedge clk); #2;
        a_q.push_back('{addr: 5'd3, data: 32'h11});
        a_q.push_back('{addr: 5'd3, data: 32'h11});
        b_q.push_back('{addr: 5'd4, data: 32'h22});
        b_q.push_back('{addr: 5'd4, data: 32'h22});
        wait_idle(20);
        chk("rd3", 64'(bank[3]), 64'h11);
        chk("rd4", 64'(bank[4]), 64'h22);

        // Reset in the cycle right after an accepted write to register 7.
        begin
            logic seen = 1'b0;
            a_q.push_back('{addr: 5'd7, data: 32'h7777_7777});
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = bus.a_valid && bus.a_ready;
            end
            chk("a7_accepted", 64'(seen), 64'd1);
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1 chk("regwrite_drop", 64'(bus.regwrite), 64'd0);
            repeat (2) @(posedge clk);
            #2 rst_n = 1'b1;
            @(posedge clk); #1;
            chk("restart_wa", 64'({bus.regwrite, bus.wa}), 64'({1'b1, 5'd1}));
            wait_init();
            wait_idle(20);
        end

        gaps = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a_q.push_back('{addr: ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
                            data: $urandom});
            b_q.push_back('{addr: ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3)),
                            data: $urandom});
        end
        wait_idle(3000);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) chk("bank_final", 64'(bank[i]), 64'(ref_rf[i]));
        chk("exp_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
